// File: rtl/tt_um_jimktrains_vslc_instr_fetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tt_um_jimktrains_vslc_instr_fetch
//
// Instruction fetch stage that sits behind the VSLC EEPROM reader. It turns
// the reader's serial byte stream into 16-bit big-endian instruction words,
// queues them in a small FIFO for the core, and drives the reader's restart
// (goto_address/address) and back-pressure (hold_n) inputs.
//
// Parameters
//   DEPTH      FIFO depth in words (power of two, 2..16)
//   GOTO_HOLD  clk cycles goto_address is held high on a jump
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   read_ready    reader byte-complete level (edge detected here)
//   byte_read     reader data byte, valid while read_ready is high
//   goto_address  restart request to the reader
//   address       byte address to the reader, {target_word, 1'b0}
//   hold_n        low stalls the reader's SPI stream
//   jump          one-cycle refetch request from the core
//   jump_addr     refetch target (word address)
//   instr_valid   FIFO head is valid
//   instr         FIFO head word
//   instr_ready   core pops the head on instr_valid && instr_ready
//   overflow      sticky: a word arrived while the FIFO was full
//   instr_pc      (VSLC_FETCH_PC_EN only) word address of the head entry
//
// Build option: define VSLC_FETCH_PC_EN to add per-entry PC tracking and
// the instr_pc output.
// ---------------------------------------------------------------------------
module tt_um_jimktrains_vslc_instr_fetch #(
    parameter int DEPTH     = 4,
    parameter int GOTO_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_ready,
    input  logic [7:0]  byte_read,
    output logic        goto_address,
    output logic [9:0]  address,
    output logic        hold_n,
    input  logic        jump,
    input  logic [8:0]  jump_addr,
    output logic        instr_valid,
    output logic [15:0] instr,
    input  logic        instr_ready,
`ifdef VSLC_FETCH_PC_EN
    output logic [8:0]  instr_pc,
`endif
    output logic        overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(GOTO_HOLD + 1);

    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    // One slot of margin: a byte may already be in flight when hold_n drops.
    localparam logic [CW-1:0] HOLD_THRESH = CW'(DEPTH - 1);
    localparam logic [HW-1:0] HOLD_LOAD   = HW'(GOTO_HOLD - 1);

    typedef enum logic {
        STREAM = 1'b0,
        GOTO   = 1'b1
    } state_t;

    state_t          state_reg;
    logic [HW-1:0]   hold_cnt_reg;
    logic [8:0]      target_word_reg;
    logic            rr_prev_reg;
    logic            half_reg;
    logic [7:0]      high_byte_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            goto_address_reg;
    logic            hold_n_reg;
    logic            overflow_reg;

    logic            byte_take;
    logic            word_done;
    logic            fifo_full;
    logic            push_ok;
    logic            pop_ok;
    logic [15:0]     word_next;

    logic [15:0]     entry_data [DEPTH];

    // A jump overrides everything else in its cycle: no capture, no pop.
    always_comb begin
        byte_take = (state_reg == STREAM) && !jump && read_ready && !rr_prev_reg;
        word_done = byte_take && half_reg;
        fifo_full = (count_reg == FULL_CNT);
        push_ok   = word_done && !fifo_full;
        pop_ok    = !jump && instr_ready && (count_reg != '0);
        word_next = {high_byte_reg, byte_read};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= STREAM;
            hold_cnt_reg     <= '0;
            target_word_reg  <= '0;
            rr_prev_reg      <= 1'b1;
            half_reg         <= 1'b0;
            high_byte_reg    <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            goto_address_reg <= 1'b0;
            hold_n_reg       <= 1'b1;
            overflow_reg     <= 1'b0;
        end else begin
            rr_prev_reg <= read_ready;
            // Registered from the current count, so it lags a count change by one clk.
            hold_n_reg  <= (count_reg < HOLD_THRESH);

            if (jump) begin
                // Entering (or re-entering) GOTO: flush and restart the reader.
                state_reg        <= GOTO;
                hold_cnt_reg     <= HOLD_LOAD;
                target_word_reg  <= jump_addr;
                goto_address_reg <= 1'b1;
                // Treat read_ready as already high so a stale level is not a byte.
                rr_prev_reg      <= 1'b1;
                half_reg         <= 1'b0;
                wr_ptr_reg       <= '0;
                rd_ptr_reg       <= '0;
                count_reg        <= '0;
            end else begin
                case (state_reg)
                    STREAM: begin
                        if (byte_take) begin
                            if (!half_reg) begin
                                high_byte_reg <= byte_read;
                                half_reg      <= 1'b1;
                            end else begin
                                half_reg <= 1'b0;
                                if (fifo_full) begin
                                    overflow_reg <= 1'b1;
                                end
                            end
                        end
                    end
                    GOTO: begin
                        if (hold_cnt_reg == '0) begin
                            state_reg        <= STREAM;
                            goto_address_reg <= 1'b0;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg - 1'b1;
                        end
                    end
                    default: state_reg <= STREAM;
                endcase

                if (push_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                if (push_ok && !pop_ok) begin
                    count_reg <= count_reg + 1'b1;
                end else if (!push_ok && pop_ok) begin
                    count_reg <= count_reg - 1'b1;
                end
            end
        end
    end

    // FIFO storage: one register per slot, written when the write pointer
    // selects it. Registers (not RAM) because the head is read combinationally.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [15:0] data_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (push_ok && (wr_ptr_reg == PW'(gi))) begin
                    data_reg <= word_next;
                end
            end

            assign entry_data[gi] = data_reg;
        end
    endgenerate

`ifdef VSLC_FETCH_PC_EN
    // Word counter follows the reader: it restarts at the jump target and
    // advances once per completed word, dropped or not, so PCs stay aligned
    // with the byte stream.
    logic [8:0] pc_cnt_reg;
    logic [8:0] entry_pc [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_cnt_reg <= '0;
        end else if (jump) begin
            pc_cnt_reg <= jump_addr;
        end else if (word_done) begin
            pc_cnt_reg <= pc_cnt_reg + 9'd1;
        end
    end

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pc
            logic [8:0] pc_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pc_reg <= '0;
                end else if (push_ok && (wr_ptr_reg == PW'(gi))) begin
                    pc_reg <= pc_cnt_reg;
                end
            end

            assign entry_pc[gi] = pc_reg;
        end
    endgenerate

    assign instr_pc = entry_pc[rd_ptr_reg];
`endif

    assign goto_address = goto_address_reg;
    assign address      = {target_word_reg, 1'b0};
    assign hold_n       = hold_n_reg;
    assign instr_valid  = (count_reg != '0);
    assign instr        = entry_data[rd_ptr_reg];
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_instr_fetch.sv
`timescale 1ns/1ps
// Testbench for tt_um_jimktrains_vslc_instr_fetch.
// The stimulus process acts as the EEPROM reader and the core; a reference
// model (queue of expected words) is updated when bytes and jumps are issued,
// and a separate monitor pops and compares whenever the DUT hands a word over.
module tb_tt_um_jimktrains_vslc_instr_fetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_ready;
    logic [7:0]  byte_read;
    logic        goto_address;
    logic [9:0]  address;
    logic        hold_n;
    logic        jump;
    logic [8:0]  jump_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        overflow;
`ifdef VSLC_FETCH_PC_EN
    logic [8:0]  instr_pc;
`endif

    tt_um_jimktrains_vslc_instr_fetch #(.DEPTH(DEPTH), .GOTO_HOLD(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .read_ready   (read_ready),
        .byte_read    (byte_read),
        .goto_address (goto_address),
        .address      (address),
        .hold_n       (hold_n),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
`ifdef VSLC_FETCH_PC_EN
        .instr_pc     (instr_pc),
`endif
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] w;
        logic [8:0]  pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;

    // Reference model state (reader/fetch abstraction)
    bit         m_half;
    logic [7:0] m_hi;
    logic [8:0] m_pc;
    int         ready_mode;   // 0: never pop, 1: always pop, 2: random

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endtask

    // Advance one clock; inputs change 1ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (ready_mode == 2) instr_ready = 1'($urandom_range(0, 1));
        else                 instr_ready = (ready_mode == 1);
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        if (!m_half) begin
            m_hi   = b;
            m_half = 1'b1;
        end else begin
            m_half = 1'b0;
            e.w    = {m_hi, b};
            e.pc   = m_pc;
            // Full is judged before any pop in the same cycle.
            if (exp_q.size() < DEPTH) exp_q.push_back(e);
            m_pc = m_pc + 9'd1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo, input bit wait_hold);
        int t;
        t = 0;
        while (wait_hold && !hold_n && t < 300) begin
            step();
            t++;
        end
        if (wait_hold && !hold_n) check("hold_wait_timeout", 32'(hold_n), 32'd1);
        model_byte(b);
        byte_read  = b;
        read_ready = 1'b1;
        repeat (hi) step();
        read_ready = 1'b0;
        repeat (lo) step();
    endtask

    task automatic do_jump(input logic [8:0] a);
        jump      = 1'b1;
        jump_addr = a;
        exp_q.delete();
        m_half    = 1'b0;
        m_pc      = a;
        $display("jump addr=0x%03h", a);
        step();
        jump = 1'b0;
    endtask

    task automatic wait_goto_end(output int n);
        n = 0;
        while (goto_address && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic drain();
        int t;
        ready_mode = 1;
        t = 0;
        while ((instr_valid || exp_q.size() != 0) && t < 300) begin
            step();
            t++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_valid_low", 32'(instr_valid), 32'd0);
        ready_mode = 0;
        step();
    endtask

    // Monitor: one comparison per handshake seen by the DUT at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && instr_valid && instr_ready && !jump) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got instr=0x%04h expected no valid word", instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("pop instr=0x%04h expected=0x%04h pc=0x%03h", instr, mon_e.w, mon_e.pc);
                    check("pop_instr", 32'(instr), 32'(mon_e.w));
`ifdef VSLC_FETCH_PC_EN
                    check("pop_pc", 32'(instr_pc), 32'(mon_e.pc));
`endif
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; read_ready = 1'b0; byte_read = 8'h00; jump = 1'b0;
        jump_addr = 9'h000; instr_ready = 1'b0; ready_mode = 0;
        m_half = 1'b0; m_hi = 8'h00; m_pc = 9'h000;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst_goto_address", 32'(goto_address), 32'd0);
        check("rst_hold_n", 32'(hold_n), 32'd1);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_address", 32'(address), 32'd0);
`ifdef VSLC_FETCH_PC_EN
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
`endif
        step();

        // First word: 0x12 then 0x34, each held high 3 clk
        send_byte(8'h12, 3, 2, 1'b0);
        model_byte(8'h34);
        byte_read = 8'h34; read_ready = 1'b1;
        @(negedge clk);
        check("latency_before_edge", 32'(instr_valid), 32'd0);
        step();
        check("latency_valid", 32'(instr_valid), 32'd1);
        check("first_word", 32'(instr), 32'h1234);
`ifdef VSLC_FETCH_PC_EN
        check("first_pc", 32'(instr_pc), 32'd0);
`endif
        repeat (2) step();
        read_ready = 1'b0;
        repeat (2) step();
        check("still_one_word_hold_n", 32'(hold_n), 32'd1);
        drain();

        // Back-pressure: core does not pop
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 2, 2, 1'b1);
        check("hold_n_two_words", 32'(hold_n), 32'd1);
        send_byte(8'h05, 2, 2, 1'b1);
        send_byte(8'h06, 2, 2, 1'b1);
        check("hold_n_three_words", 32'(hold_n), 32'd0);
        check("no_overflow", 32'(overflow), 32'd0);
        step();
        instr_ready = 1'b1;
        step();
        step();
        check("hold_n_after_pop", 32'(hold_n), 32'd1);
        send_byte(8'h07, 2, 2, 1'b1);
        send_byte(8'h08, 2, 2, 1'b1);

        // Overflow: reader ignores hold_n
        send_byte(8'h09, 1, 1, 1'b0);
        send_byte(8'h0A, 1, 1, 1'b0);
        check("full_no_overflow_yet", 32'(overflow), 32'd0);
        send_byte(8'h0B, 1, 1, 1'b0);
        send_byte(8'h0C, 1, 1, 1'b0);
        check("overflow_set", 32'(overflow), 32'd1);
        drain();
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Jump with 2 words and a pending high byte
        for (int i = 0; i < 5; i++) send_byte(8'(8'h21 + i), 1, 1, 1'b0);
        do_jump(9'h05B);
        check("jump_flush_valid", 32'(instr_valid), 32'd0);
        check("jump_address", 32'(address), 32'h0B6);
        check("jump_goto_high", 32'(goto_address), 32'd1);
        n = 0;
        while (goto_address && n < 100) begin
            n++;
            read_ready = n[1];
            byte_read  = 8'($urandom);
            step();
        end
        read_ready = 1'b0;
        check("goto_hold_cycles", 32'(n), 32'd8);
        check("address_stable", 32'(address), 32'h0B6);
        send_byte(8'hAB, 2, 1, 1'b1);
        send_byte(8'hCD, 2, 1, 1'b1);
        check("after_jump_word", 32'(instr), 32'hABCD);
`ifdef VSLC_FETCH_PC_EN
        check("after_jump_pc", 32'(instr_pc), 32'h05B);
`endif
        drain();

        // read_ready left high across the GOTO exit
        do_jump(9'h100);
        byte_read = 8'h77; read_ready = 1'b1;
        wait_goto_end(n);
        check("goto_hold_cycles_2", 32'(n), 32'd8);
        repeat (3) step();
        read_ready = 1'b0;
        step();
        send_byte(8'h99, 2, 2, 1'b1);
        check("stale_rr_no_word", 32'(instr_valid), 32'd0);
        send_byte(8'h88, 2, 2, 1'b1);
        check("stale_rr_word", 32'(instr), 32'h9988);
        drain();

        // Jump and pop in the same cycle, then a second jump mid-GOTO
        for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i), 1, 1, 1'b0);
        instr_ready = 1'b1;
        do_jump(9'h0A0);
        check("jump_pop_flush", 32'(instr_valid), 32'd0);
        check("jump_pop_address", 32'(address), 32'h140);
        repeat (2) step();
        do_jump(9'h1F3);
        check("rejump_address", 32'(address), 32'h3E6);
        wait_goto_end(n);
        check("rejump_hold_cycles", 32'(n), 32'd8);
        send_byte(8'h5A, 1, 1, 1'b1);
        send_byte(8'hA5, 1, 1, 1'b1);
        check("rejump_single_word", 32'(instr), 32'h5AA5);
        drain();

        // Randomized traffic with random pops and occasional jumps
        ready_mode = 2;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                do_jump(9'($urandom_range(0, 511)));
                wait_goto_end(n);
                check("rand_goto_cycles", 32'(n), 32'd8);
            end else begin
                send_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(1, 3), 1'b1);
            end
        end
        drain();
        check("final_overflow_sticky", 32'(overflow), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
